simple_cpu_core: RTL and testbench



---
 rtl/simple_cpu_core_pkg.sv | 34 +++
 rtl/cpu_alu.sv | 27 ++
 rtl/simple_cpu_core.sv | 151 +++++++++++++++
 tb/tb_simple_cpu_core.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_cpu_core_pkg.sv
// Shared definitions for the accumulator CPU: state encoding, opcodes and
// instruction field positions.
package simple_cpu_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_OUT = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int ARG_MSB = 3;
  localparam int ARG_LSB = 0;

  // Zero-extend the 4-bit operand into a byte address / immediate.
  function automatic logic [7:0] operand_byte(input logic [7:0] ir);
    return {4'h0, ir[ARG_MSB:ARG_LSB]};
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit add/subtract. Carry is bit 8 of the 9-bit result,
// which for subtraction is the borrow (a < b).
module cpu_alu (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       sub_i,
  output logic [7:0] result_o,
  output logic       carry_o,
  output logic       zero_o
);

  logic [8:0] wide;

  // 9-bit sum or difference; the top bit is carry-out / borrow.
  always_comb begin
    if (sub_i) begin
      wide = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      wide = {1'b0, a_i} + {1'b0, b_i};
    end
  end

  assign result_o = wide[7:0];
  assign carry_o  = wide[8];
  assign zero_o   = (wide[7:0] == 8'h00);

endmodule

// File: rtl/simple_cpu_core.sv
// 8-bit accumulator CPU. Fetches instructions and memory operands through a
// zero-wait asynchronous RAM side port; results leave on a registered byte
// with a one-cycle valid strobe.
module simple_cpu_core
  import simple_cpu_core_pkg::*;
#(
  parameter int PROG_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  output logic [7:0] o_ram_addr,
  input  logic [7:0] i_ram_data,
  output logic [7:0] o_out,
  output logic       o_out_valid,
  output logic       o_halted,
  output logic [7:0] o_pc
);

  localparam logic [7:0] PC_LAST = 8'(PROG_LEN - 1);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic       c_q, c_d;
  logic       z_q, z_d;
  logic [7:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic [3:0] opcode;
  logic [7:0] ram_addr;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_zero;

  assign opcode = ir_q[OPC_MSB:OPC_LSB];

  // The ALU always sees acc and the current RAM byte; only MEM commits it.
  cpu_alu u_alu (
    .a_i      (acc_q),
    .b_i      (i_ram_data),
    .sub_i    (opcode == OP_SUB),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero)
  );

  // Next-state, datapath updates and RAM address for each FSM state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    acc_d       = acc_q;
    c_d         = c_q;
    z_d         = z_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ram_addr    = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (i_run) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (!i_run) begin
          state_d = ST_IDLE;
        end else begin
          ir_d    = i_ram_data;
          pc_d    = (pc_q == PC_LAST) ? 8'h00 : pc_q + 8'h01;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_LDI: begin
            acc_d = operand_byte(ir_q);
            z_d   = (ir_q[ARG_MSB:ARG_LSB] == 4'h0);
          end
          OP_LDA, OP_ADD, OP_SUB: state_d = ST_MEM;
          OP_OUT: begin
            out_d       = acc_q;
            out_valid_d = 1'b1;
          end
          OP_JMP: pc_d = operand_byte(ir_q);
          OP_JC:  if (c_q) pc_d = operand_byte(ir_q);
          OP_JZ:  if (z_q) pc_d = operand_byte(ir_q);
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end

      ST_MEM: begin
        ram_addr = operand_byte(ir_q);
        state_d  = ST_FETCH;
        if (opcode == OP_LDA) begin
          acc_d = i_ram_data;
          z_d   = (i_ram_data == 8'h00);
        end else begin
          acc_d = alu_result;
          c_d   = alu_carry;
          z_d   = alu_zero;
        end
      end

      ST_HALT: begin
        if (!i_run) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Architectural state registers; reset may land mid-instruction.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= 8'h00;
      ir_q        <= 8'h00;
      acc_q       <= 8'h00;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      z_q         <= z_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_ram_addr  = ram_addr;
  assign o_out       = out_q;
  assign o_out_valid = out_valid_q;
  assign o_halted    = (state_q == ST_HALT);
  assign o_pc        = pc_q;

endmodule

// File: tb/tb_simple_cpu_core.sv
// Self-checking bench for simple_cpu_core: a RAM model answers the side port
// combinationally, expected OUT bytes are queued by each scenario and popped
// by a monitor whenever o_out_valid pulses.
module tb_simple_cpu_core;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_run = 1'b0;
  logic [7:0] o_ram_addr;
  logic [7:0] i_ram_data;
  logic [7:0] o_out;
  logic       o_out_valid;
  logic       o_halted;
  logic [7:0] o_pc;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;
  int         checks = 0;
  int         failures = 0;
  int         pulses = 0;

  assign i_ram_data = mem[o_ram_addr];

  always #5 i_clk = ~i_clk;

  simple_cpu_core #(.PROG_LEN(16)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_run       (i_run),
    .o_ram_addr  (o_ram_addr),
    .i_ram_data  (i_ram_data),
    .o_out       (o_out),
    .o_out_valid (o_out_valid),
    .o_halted    (o_halted),
    .o_pc        (o_pc)
  );

  // Scoreboard: every valid pulse must match the oldest queued expectation.
  always @(negedge i_clk) begin
    if (!i_reset && o_out_valid) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected got=%02h expected=none", o_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_out !== mon_exp) begin
          failures++;
          $display("FAIL out_value got=%02h expected=%02h", o_out, mon_exp);
        end else begin
          $display("OUT  got=%02h expected=%02h ok", o_out, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic reset_dut();
    i_run   = 1'b0;
    i_reset = 1'b1;
    #2;
    i_reset = 1'b0;
    exp_q.delete();
    pulses = 0;
    step();
  endtask

  task automatic wait_halt(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (o_halted) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem();
    i_run   = 1'b0;
    i_reset = 1'b1;
    #1;
    checks++; if (o_pc !== 8'h00)       begin failures++; $display("FAIL reset_pc got=%02h expected=00", o_pc); end
    checks++; if (o_out !== 8'h00)      begin failures++; $display("FAIL reset_out got=%02h expected=00", o_out); end
    checks++; if (o_out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", o_out_valid); end
    checks++; if (o_halted !== 1'b0)    begin failures++; $display("FAIL reset_halted got=%b expected=0", o_halted); end
    checks++; if (o_ram_addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%02h expected=00", o_ram_addr); end
    i_reset = 1'b0;
    step();
    $display("TXN reset pc=%02h addr=%02h", o_pc, o_ram_addr);
  endtask

  task automatic test_basic();
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h50; mem[2] = 8'hF0;
    reset_dut();
    exp_q.push_back(8'h05);
    i_run = 1'b1;
    repeat (6) step();
    checks++; if (o_halted !== 1'b0) begin failures++; $display("FAIL basic_halt_early got=%b expected=0", o_halted); end
    step();
    checks++; if (o_halted !== 1'b1) begin failures++; $display("FAIL basic_halt_cycle got=%b expected=1", o_halted); end
    checks++; if (o_out !== 8'h05)   begin failures++; $display("FAIL basic_out got=%02h expected=05", o_out); end
    checks++; if (pulses != 1)       begin failures++; $display("FAIL basic_pulses got=%0d expected=1", pulses); end
    checks++; if (o_pc !== 8'h03)    begin failures++; $display("FAIL basic_pc got=%02h expected=03", o_pc); end
    i_run = 1'b0;
    step();
    checks++; if (o_halted !== 1'b0) begin failures++; $display("FAIL basic_unhalt got=%b expected=0", o_halted); end
    $display("TXN basic out=%02h pc=%02h", o_out, o_pc);
  endtask

  task automatic test_add_overflow();
    bit ok;
    clear_mem();
    mem[0] = 8'h11;   // LDI 1
    mem[1] = 8'h3F;   // ADD 15 -> 0x00, C=1, Z=1
    mem[2] = 8'h76;   // JC 6
    mem[3] = 8'hF0;
    mem[6] = 8'h89;   // JZ 9
    mem[7] = 8'hF0;
    mem[9] = 8'h50;   // OUT
    mem[10] = 8'hF0;
    mem[15] = 8'hFF;
    reset_dut();
    exp_q.push_back(8'h00);
    i_run = 1'b1;
    wait_halt(60, ok);
    checks++; if (!ok)               begin failures++; $display("FAIL add_timeout got=running expected=halted"); end
    checks++; if (o_pc !== 8'h0B)    begin failures++; $display("FAIL add_pc got=%02h expected=0b", o_pc); end
    checks++; if (o_out !== 8'h00)   begin failures++; $display("FAIL add_out got=%02h expected=00", o_out); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL add_missing got=%0d expected=0", exp_q.size()); end
    $display("TXN add_overflow out=%02h pc=%02h", o_out, o_pc);
  endtask

  task automatic test_sub_borrow();
    bit ok;
    clear_mem();
    mem[0] = 8'h13;   // LDI 3
    mem[1] = 8'h4E;   // SUB 14 -> 0xFF, C=1, Z=0
    mem[2] = 8'h89;   // JZ 9 (not taken)
    mem[3] = 8'h50;   // OUT
    mem[4] = 8'h77;   // JC 7 (taken)
    mem[5] = 8'hF0;
    mem[7] = 8'h50;   // OUT
    mem[8] = 8'hF0;
    mem[9] = 8'hF0;
    mem[14] = 8'h04;
    reset_dut();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    i_run = 1'b1;
    repeat (7) step();
    checks++; if (o_pc !== 8'h03) begin failures++; $display("FAIL sub_pc_fetch got=%02h expected=03", o_pc); end
    step();
    checks++; if (o_pc !== 8'h03) begin failures++; $display("FAIL sub_jz_not_taken got=%02h expected=03", o_pc); end
    wait_halt(60, ok);
    checks++; if (!ok)               begin failures++; $display("FAIL sub_timeout got=running expected=halted"); end
    checks++; if (o_pc !== 8'h09)    begin failures++; $display("FAIL sub_pc_end got=%02h expected=09", o_pc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sub_missing got=%0d expected=0", exp_q.size()); end
    $display("TXN sub_borrow out=%02h pc=%02h", o_out, o_pc);
  endtask

  task automatic test_pc_wrap();
    logic [7:0] want;
    clear_mem();
    reset_dut();
    i_run = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      want = 8'((k / 2) % 16);
      checks++;
      if (o_ram_addr !== want || o_pc > 8'd15) begin
        failures++;
        $display("FAIL wrap_addr cycle=%0d got=%02h expected=%02h pc=%02h", k, o_ram_addr, want, o_pc);
      end
    end
    i_run = 1'b0;
    step();
    $display("TXN pc_wrap addr=%02h pc=%02h", o_ram_addr, o_pc);
  endtask

  task automatic test_pause();
    bit ok;
    clear_mem();
    mem[0] = 8'h12;   // LDI 2
    mem[1] = 8'h3F;   // ADD 15
    mem[2] = 8'h50;   // OUT
    mem[3] = 8'hF0;
    mem[15] = 8'h03;
    reset_dut();
    i_run = 1'b1;
    repeat (5) step();
    checks++; if (o_ram_addr !== 8'h0F) begin failures++; $display("FAIL pause_in_mem got=%02h expected=0f", o_ram_addr); end
    i_run = 1'b0;
    repeat (4) step();
    checks++; if (o_pc !== 8'h02)       begin failures++; $display("FAIL pause_pc got=%02h expected=02", o_pc); end
    checks++; if (o_ram_addr !== 8'h02) begin failures++; $display("FAIL pause_addr got=%02h expected=02", o_ram_addr); end
    checks++; if (pulses != 0)          begin failures++; $display("FAIL pause_pulses got=%0d expected=0", pulses); end
    exp_q.push_back(8'h05);
    i_run = 1'b1;
    wait_halt(40, ok);
    checks++; if (!ok)               begin failures++; $display("FAIL pause_timeout got=running expected=halted"); end
    checks++; if (o_out !== 8'h05)   begin failures++; $display("FAIL pause_out got=%02h expected=05", o_out); end
    checks++; if (o_pc !== 8'h04)    begin failures++; $display("FAIL pause_pc_end got=%02h expected=04", o_pc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL pause_missing got=%0d expected=0", exp_q.size()); end
    i_run = 1'b0;
    step();
    $display("TXN pause out=%02h pc=%02h", o_out, o_pc);
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_mem();
    mem[0] = 8'h19;   // LDI 9
    mem[1] = 8'h50;   // OUT
    mem[2] = 8'h3F;   // ADD 15
    mem[3] = 8'h50;   // OUT
    mem[4] = 8'hF0;
    mem[15] = 8'h03;
    reset_dut();
    exp_q.push_back(8'h09);
    i_run = 1'b1;
    repeat (7) step();
    checks++; if (o_ram_addr !== 8'h0F) begin failures++; $display("FAIL rmid_in_mem got=%02h expected=0f", o_ram_addr); end
    checks++; if (o_out !== 8'h09)      begin failures++; $display("FAIL rmid_pre_out got=%02h expected=09", o_out); end
    #1;
    i_reset = 1'b1;
    #1;
    checks++; if (o_out !== 8'h00 || o_pc !== 8'h00 || o_ram_addr !== 8'h00 || o_out_valid !== 1'b0 || o_halted !== 1'b0) begin
      failures++;
      $display("FAIL rmid_async got=out%02h pc%02h addr%02h v%b h%b expected=all zero",
               o_out, o_pc, o_ram_addr, o_out_valid, o_halted);
    end
    #1;
    i_reset = 1'b0;
    exp_q.push_back(8'h09);
    exp_q.push_back(8'h0C);
    step();
    checks++; if (o_ram_addr !== 8'h00) begin failures++; $display("FAIL rmid_fetch0 got=%02h expected=00", o_ram_addr); end
    step();
    checks++; if (o_pc !== 8'h01)       begin failures++; $display("FAIL rmid_pc1 got=%02h expected=01", o_pc); end
    wait_halt(40, ok);
    checks++; if (!ok)               begin failures++; $display("FAIL rmid_timeout got=running expected=halted"); end
    checks++; if (o_out !== 8'h0C)   begin failures++; $display("FAIL rmid_out got=%02h expected=0c", o_out); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmid_missing got=%0d expected=0", exp_q.size()); end
    i_run = 1'b0;
    step();
    $display("TXN reset_mid out=%02h pc=%02h", o_out, o_pc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_add_overflow();
    test_sub_borrow();
    test_pc_wrap();
    test_pause();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
